// File: rtl/motoro301_pkg.sv
// motoro301 shared types and defaults.
// State encoding is visible on the debug port, so values are fixed.
package motoro301_pkg;

   localparam int FREQ_W          = 10;
   localparam int F_MIN_DEF       = 10;
   localparam int STEP_TICKS_DEF  = 50000;
   localparam int ALIGN_TICKS_DEF = 5000000;
   localparam int DWELL_TICKS_DEF = 2500000;
   localparam int CNT_W           = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_RUN   = 3'd2,
      ST_BRAKE = 3'd3,
      ST_DWELL = 3'd4
   } state_e;

endpackage

// File: rtl/motoro301_tick_cnt.sv
// Wrapping up-counter with clear and terminal-count pulse.
// Counts 0..term_i and wraps, so tc_o fires every term_i+1 cycles.
module motoro301_tick_cnt #(
   parameter int W = motoro301_pkg::CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] term_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc_o = en_i & (cnt_q == term_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/motoro301_ramp_ctrl.sv
// Run/direction sequencer: align, soft-start, run, soft-stop, dwell.
// Direction is only ever latched with the bridge off (IDLE->ALIGN).
module motoro301_ramp_ctrl #(
   parameter int FREQ_W      = motoro301_pkg::FREQ_W,
   parameter int F_MIN       = motoro301_pkg::F_MIN_DEF,
   parameter int STEP_TICKS  = motoro301_pkg::STEP_TICKS_DEF,
   parameter int ALIGN_TICKS = motoro301_pkg::ALIGN_TICKS_DEF,
   parameter int DWELL_TICKS = motoro301_pkg::DWELL_TICKS_DEF
) (
   input  logic              clk50mhz,
   input  logic              reset,
   input  logic              m3start,
   input  logic              m3invOrStop,
   input  logic [FREQ_W-1:0] m3freq,
   output logic [FREQ_W-1:0] freqOut,
   output logic              dirOut,
   output logic              drvEn,
   output logic              atSpeed,
   output logic [2:0]        state
);

   import motoro301_pkg::*;

   localparam logic [FREQ_W-1:0] FMIN_V  = FREQ_W'(F_MIN);
   localparam logic [CNT_W-1:0]  STEP_T  = CNT_W'(STEP_TICKS - 1);
   localparam logic [CNT_W-1:0]  ALIGN_T = CNT_W'(ALIGN_TICKS - 1);
   localparam logic [CNT_W-1:0]  DWELL_T = CNT_W'(DWELL_TICKS - 1);

   logic              start_q;
   logic              inv_q;
   logic [FREQ_W-1:0] mfreq_q;

   state_e            state_q, state_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic              dir_q, dir_d;
   logic              drv_q, drv_d;
   logic              at_q, at_d;

   logic [FREQ_W-1:0] tgt;
   logic              run_req;
   logic              entry;
   logic              step_tc;
   logic              tmr_tc;
   logic [CNT_W-1:0]  tmr_term;

   assign tgt      = (mfreq_q < FMIN_V) ? FMIN_V : mfreq_q;
   assign run_req  = start_q & (mfreq_q != '0);
   assign entry    = (state_d != state_q);
   assign tmr_term = (state_q == ST_ALIGN) ? ALIGN_T : DWELL_T;

   motoro301_tick_cnt #(.W(CNT_W)) u_step (
      .clk_i  (clk50mhz),
      .rst_i  (reset),
      .clr_i  (entry),
      .en_i   (1'b1),
      .term_i (STEP_T),
      .tc_o   (step_tc)
   );

   motoro301_tick_cnt #(.W(CNT_W)) u_tmr (
      .clk_i  (clk50mhz),
      .rst_i  (reset),
      .clr_i  (entry),
      .en_i   (1'b1),
      .term_i (tmr_term),
      .tc_o   (tmr_tc)
   );

   always_comb begin
      state_d = state_q;
      freq_d  = freq_q;
      dir_d   = dir_q;
      unique case (state_q)
         ST_IDLE: begin
            if (run_req) begin
               state_d = ST_ALIGN;
               dir_d   = inv_q;
            end
         end
         ST_ALIGN: begin
            if (!run_req) begin
               state_d = ST_DWELL;
            end else if (tmr_tc) begin
               state_d = ST_RUN;
               freq_d  = FMIN_V;
            end
         end
         ST_RUN: begin
            if (!run_req || (inv_q != dir_q)) begin
               state_d = ST_BRAKE;
            end else if (step_tc) begin
               if (freq_q < tgt) begin
                  freq_d = freq_q + FREQ_W'(1);
               end else if (freq_q > tgt) begin
                  freq_d = freq_q - FREQ_W'(1);
               end
            end
         end
         ST_BRAKE: begin
            if (step_tc) begin
               if (freq_q == FMIN_V) begin
                  state_d = ST_DWELL;
                  freq_d  = '0;
               end else begin
                  freq_d = freq_q - FREQ_W'(1);
               end
            end
         end
         ST_DWELL: begin
            if (tmr_tc) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            freq_d  = '0;
         end
      endcase
      drv_d = (state_d == ST_ALIGN) || (state_d == ST_RUN) ||
              (state_d == ST_BRAKE);
      // Cleared on the very edge that leaves RUN.
      at_d  = (state_q == ST_RUN) && (state_d == ST_RUN) &&
              (freq_q == tgt);
   end

   always_ff @(posedge clk50mhz) begin
      if (reset) begin
         start_q <= 1'b0;
         inv_q   <= 1'b0;
         mfreq_q <= '0;
         state_q <= ST_IDLE;
         freq_q  <= '0;
         dir_q   <= 1'b0;
         drv_q   <= 1'b0;
         at_q    <= 1'b0;
      end else begin
         start_q <= m3start;
         inv_q   <= m3invOrStop;
         mfreq_q <= m3freq;
         state_q <= state_d;
         freq_q  <= freq_d;
         dir_q   <= dir_d;
         drv_q   <= drv_d;
         at_q    <= at_d;
      end
   end

   assign freqOut = freq_q;
   assign dirOut  = dir_q;
   assign drvEn   = drv_q;
   assign atSpeed = at_q;
   assign state   = state_q;

endmodule

// File: tb/tb_motoro301_ramp_ctrl.sv
// Bench for motoro301_ramp_ctrl: fixed vectors, corner sequences,
// and random commands against a cycle-count reference model.
module tb_motoro301_ramp_ctrl;

   localparam int STEP  = 4;
   localparam int ALIGN = 8;
   localparam int DWELL = 6;
   localparam int FMIN  = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       inv = 1'b0;
   logic [9:0] freq = '0;
   logic [9:0] freqOut;
   logic       dirOut;
   logic       drvEn;
   logic       atSpeed;
   logic [2:0] state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   motoro301_ramp_ctrl #(
      .FREQ_W      (10),
      .F_MIN       (FMIN),
      .STEP_TICKS  (STEP),
      .ALIGN_TICKS (ALIGN),
      .DWELL_TICKS (DWELL)
   ) dut (
      .clk50mhz    (clk),
      .reset       (rst),
      .m3start     (start),
      .m3invOrStop (inv),
      .m3freq      (freq),
      .freqOut     (freqOut),
      .dirOut      (dirOut),
      .drvEn       (drvEn),
      .atSpeed     (atSpeed),
      .state       (state)
   );

   // Reference model: mode 0..4 = idle/align/run/brake/dwell,
   // age = cycles spent in the current mode.
   int         m_mode = 0;
   int         m_age = 0;
   logic       m_s = 0, m_i = 0;
   int         m_f = 0;
   int         m_freq = 0;
   int         m_dir = 0;
   int         m_en = 0;
   int         m_at = 0;

   task automatic model_edge(input logic r, input logic s,
                             input logic i, input logic [9:0] f);
      int nm, nf, nd, tg;
      bit rr, tick;
      if (r) begin
         m_mode = 0; m_age = 0; m_s = 0; m_i = 0; m_f = 0;
         m_freq = 0; m_dir = 0; m_en = 0; m_at = 0;
         return;
      end
      rr   = m_s && (m_f != 0);
      tg   = (m_f < FMIN) ? FMIN : m_f;
      tick = (m_age % STEP) == STEP - 1;
      nm = m_mode; nf = m_freq; nd = m_dir;
      case (m_mode)
         0: if (rr) begin nm = 1; nd = int'(m_i); end
         1: if (!rr) nm = 4;
            else if (m_age == ALIGN - 1) begin nm = 2; nf = FMIN; end
         2: if (!rr || int'(m_i) != m_dir) nm = 3;
            else if (tick) nf = m_freq + ((m_freq < tg) ? 1 :
                                          (m_freq > tg) ? -1 : 0);
         3: if (tick) begin
               if (m_freq == FMIN) begin nm = 4; nf = 0; end
               else nf = m_freq - 1;
            end
         default: if (m_age == DWELL - 1) nm = 0;
      endcase
      m_at   = (m_mode == 2 && nm == 2 && m_freq == tg) ? 1 : 0;
      m_age  = (nm != m_mode) ? 0 : m_age + 1;
      m_en   = (nm >= 1 && nm <= 3) ? 1 : 0;
      m_mode = nm; m_freq = nf; m_dir = nd;
      m_s = s; m_i = i; m_f = int'(f);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step_clk();
      logic r, s, i;
      logic [9:0] f;
      r = rst; s = start; i = inv; f = freq;
      @(posedge clk);
      model_edge(r, s, i, f);
      #1;
      chk("mdl_freq", int'(freqOut), m_freq);
      chk("mdl_state", int'(state), m_mode);
      chk("mdl_dir", int'(dirOut), m_dir);
      chk("mdl_drv", int'(drvEn), m_en);
      chk("mdl_at", int'(atSpeed), m_at);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step_clk();
   endtask

   task automatic chk_out(input string nm, input int f, input int st,
                          input int drv, input int dir, input int at);
      chk({nm, "_freq"}, int'(freqOut), f);
      chk({nm, "_state"}, int'(state), st);
      chk({nm, "_drv"}, int'(drvEn), drv);
      chk({nm, "_dir"}, int'(dirOut), dir);
      chk({nm, "_at"}, int'(atSpeed), at);
   endtask

   typedef struct {
      logic       s;
      logic       i;
      logic [9:0] f;
      int         n;
      int         ef;
      int         est;
      int         edrv;
      int         edir;
      int         eat;
   } vec_t;

   vec_t vt[$];

   initial begin
      vt.push_back('{1'b1, 1'b0, 10'd14, 1, 0, 0, 0, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 1, 0, 1, 1, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 7, 0, 1, 1, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 1, 10, 2, 1, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 3, 10, 2, 1, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 1, 11, 2, 1, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 4, 12, 2, 1, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 8, 14, 2, 1, 0, 0});
      vt.push_back('{1'b1, 1'b0, 10'd14, 1, 14, 2, 1, 0, 1});
      vt.push_back('{1'b0, 1'b0, 10'd14, 1, 14, 2, 1, 0, 1});
      vt.push_back('{1'b0, 1'b0, 10'd14, 1, 14, 3, 1, 0, 0});
      vt.push_back('{1'b0, 1'b0, 10'd14, 4, 13, 3, 1, 0, 0});
      vt.push_back('{1'b0, 1'b0, 10'd14, 12, 10, 3, 1, 0, 0});
      vt.push_back('{1'b0, 1'b0, 10'd14, 4, 0, 4, 0, 0, 0});
      vt.push_back('{1'b0, 1'b0, 10'd14, 5, 0, 4, 0, 0, 0});
      vt.push_back('{1'b0, 1'b0, 10'd14, 1, 0, 0, 0, 0, 0});

      rst = 1'b1;
      run(2);
      chk_out("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;

      for (int v = 0; v < vt.size(); v++) begin
         start = vt[v].s; inv = vt[v].i; freq = vt[v].f;
         run(vt[v].n);
         chk_out($sformatf("vec%0d", v), vt[v].ef, vt[v].est,
                 vt[v].edrv, vt[v].edir, vt[v].eat);
      end

      // Reversal request: brake, dwell, realign in reverse.
      start = 1'b1; inv = 1'b0; freq = 10'd14;
      run(26);
      chk_out("rev_run", 14, 2, 1, 0, 0);
      inv = 1'b1;
      run(2);
      chk_out("rev_brake", 14, 3, 1, 0, 0);
      run(27);
      chk_out("rev_align", 0, 1, 1, 1, 0);
      run(24);
      chk_out("rev_ramp", 14, 2, 1, 1, 0);

      // Target below F_MIN clamps, then zero target means stop.
      freq = 10'd3;
      run(20);
      chk_out("clamp", 10, 2, 1, 1, 1);
      freq = 10'd0;
      run(2);
      chk_out("zero_stop", 10, 3, 1, 1, 0);
      run(30);
      chk_out("zero_idle", 0, 0, 0, 1, 0);

      // Slew down in RUN without leaving the state.
      freq = 10'd14;
      run(27);
      chk_out("slew_14", 14, 2, 1, 1, 1);
      freq = 10'd11;
      run(3);
      chk_out("slew_13", 13, 2, 1, 1, 0);
      run(8);
      chk_out("slew_11", 11, 2, 1, 1, 0);
      run(1);
      chk_out("slew_at", 11, 2, 1, 1, 1);

      // One-cycle reset mid-ramp.
      freq = 10'd14;
      run(3);
      chk_out("pre_rst", 12, 2, 1, 1, 0);
      rst = 1'b1;
      run(1);
      chk_out("mid_rst", 0, 0, 0, 0, 0);
      rst = 1'b0;
      run(1);
      chk_out("post_rst", 0, 0, 0, 0, 0);
      run(1);
      chk_out("restart", 0, 1, 1, 1, 0);

      // Random command sequences against the model.
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            run(1);
            rst = 1'b0;
         end
         start = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) inv = ~inv;
         if ($urandom_range(0, 7) == 0) freq = '0;
         else freq = 10'($urandom_range(0, 20));
         run($urandom_range(1, 40));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
